// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : Instruction fetch stage feeding the opcode decoder.
//               Owns the PC, issues in-order word fetches over a valid/ready
//               request channel, buffers returned words with their PCs in a
//               small FIFO and presents {pc, instr, opcode} to decode over a
//               valid/ready handshake. A redirect flushes the FIFO, discards
//               every response still in flight and restarts at the new PC.
// Ports       : clk, rst_n                       clock / async active-low reset
//               imem_req_valid/ready/addr        fetch request channel
//               imem_rsp_valid/data              in-order fetch responses
//               redirect_valid/pc                branch/jump redirect pulse
//               id_valid/ready, id_pc/instr      decode handshake and payload
//               id_opcode                        id_instr[6:0]
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    // instruction memory response channel (in order, no backpressure)
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    // redirect from execute / branch unit
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // decode interface
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    localparam int              AW           = $clog2(DEPTH);
    localparam int              CW           = AW + 1;
    localparam logic [CW:0]     C_DEPTH      = DEPTH[CW:0];
    localparam logic [31:0]     C_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] C_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] C_RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;     // requests accepted, response not yet seen
    logic [CW-1:0]   r_drop;         // in-flight responses still to discard
    logic [CW-1:0]   r_count;        // valid entries in the fetch FIFO
    logic [AW-1:0]   r_fifoRd;
    logic [AW-1:0]   r_fifoWr;
    logic [AW-1:0]   r_tagRd;
    logic [AW-1:0]   r_tagWr;

    logic [XLEN-1:0] r_tagPc     [DEPTH];   // PC of each outstanding request
    logic [XLEN-1:0] r_fifoPc    [DEPTH];
    logic [31:0]     r_fifoInstr [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [CW:0]     w_occupancy;
    logic            w_credit;
    logic            w_reqFire;
    logic            w_pop;
    logic            w_dropping;
    logic            w_push;
    logic [CW-1:0]   w_inflightNext;
    logic [XLEN-1:0] w_redirectPc;
    logic            w_unusedBits;

    // Every outstanding request owns a FIFO slot in advance, so a returning
    // response can always be written without backpressure.
    assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit       = (w_occupancy < C_DEPTH);

    assign imem_req_valid = rst_n && w_credit && !redirect_valid;
    assign imem_req_addr  = r_pc;

    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign w_pop          = id_valid && id_ready;
    assign w_dropping     = (r_drop != '0);
    // A response landing in a redirect cycle belongs to the old path.
    assign w_push         = imem_rsp_valid && !w_dropping && !redirect_valid;

    assign w_inflightNext = r_inflight + CW'(w_reqFire) - CW'(imem_rsp_valid);

    assign w_redirectPc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unusedBits   = ^redirect_pc[1:0];

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= C_RESET_PC_A;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_fifoRd   <= '0;
            r_fifoWr   <= '0;
            r_tagRd    <= '0;
            r_tagWr    <= '0;
        end else begin
            r_inflight <= w_inflightNext;

            // The tag queue tracks every outstanding request, stale or not,
            // so it is never flushed: discarded responses still pop a tag.
            if (w_reqFire) begin
                r_tagWr <= r_tagWr + AW'(1);
            end
            if (imem_rsp_valid) begin
                r_tagRd <= r_tagRd + AW'(1);
            end

            if (redirect_valid) begin
                r_pc     <= w_redirectPc;
                // Everything still outstanding after this cycle is stale.
                r_drop   <= w_inflightNext;
                r_count  <= '0;
                r_fifoRd <= '0;
                r_fifoWr <= '0;
            end else begin
                if (w_reqFire) begin
                    r_pc <= r_pc + C_PC_STEP;
                end
                if (imem_rsp_valid && w_dropping) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_fifoWr <= r_fifoWr + AW'(1);
                end
                if (w_pop) begin
                    r_fifoRd <= r_fifoRd + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage (datapath, no reset needed: qualified by counters)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_reqFire) begin
            r_tagPc[r_tagWr] <= r_pc;
        end
        if (w_push) begin
            r_fifoPc[r_fifoWr]    <= r_tagPc[r_tagRd];
            r_fifoInstr[r_fifoWr] <= imem_rsp_data;
        end
    end

    // ------------------------------------------------------------------------
    // Decode outputs: FIFO head straight from storage, NOP when empty
    // ------------------------------------------------------------------------
    assign id_valid = (r_count != '0);

    always_comb begin
        id_pc    = '0;
        id_instr = C_NOP;
        if (id_valid) begin
            id_pc    = r_fifoPc[r_fifoRd];
            id_instr = r_fifoInstr[r_fifoRd];
        end
    end

    assign id_opcode = id_instr[6:0];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (w_occupancy <= C_DEPTH);
            assert (!(imem_rsp_valid && (r_inflight == '0)));
            assert (r_drop <= r_inflight);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instr_fetch_stage
// Description : Self-checking bench for instr_fetch_stage. A directed vector
//               table covers the basic pipeline, then a queue-based reference
//               model with a latency-randomised memory covers stall, redirect,
//               wrap and reset scenarios plus a long random run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_stage;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table (DEPTH = 2, RESET_PC = 0)
    // ------------------------------------------------------------------------
    typedef struct {
        logic        ready;
        logic        rspValid;
        logic [31:0] rspData;
        logic        redir;
        logic [31:0] redirPc;
        logic        idReady;
        logic        eReqValid;
        logic [31:0] eAddr;
        logic        eIdValid;
        logic [31:0] eIdPc;
        logic [31:0] eInstr;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    localparam logic [31:0] D0 = 32'h1111_0093;
    localparam logic [31:0] D1 = 32'h2222_0133;
    localparam logic [31:0] D2 = 32'h3333_01B7;
    localparam logic [31:0] D3 = 32'h4444_0263;
    localparam logic [31:0] D4 = 32'h5555_006F;
    localparam logic [31:0] D5 = 32'h6666_0003;
    localparam logic [31:0] D6 = 32'h7777_0023;

    // ------------------------------------------------------------------------
    // Reference model: outstanding requests, buffered instructions, memory
    // ------------------------------------------------------------------------
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t       mInfl[$];
    ent_t        mFifo[$];
    mreq_t       memQ[$];
    logic [31:0] mPc;
    int          cyc;
    int          lastDue;
    int          dutAccepts;
    int          consumed;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic doReset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        #1;
        check1 ("rst_req_valid", imem_req_valid, 1'b0);
        check1 ("rst_id_valid",  id_valid,       1'b0);
        check32("rst_id_instr",  id_instr,       NOP);
        check32("rst_id_pc",     id_pc,          32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mInfl.delete();
        mFifo.delete();
        memQ.delete();
        mPc        = RESET_PC;
        cyc        = 0;
        lastDue    = 0;
        dutAccepts = 0;
        consumed   = 0;
    endtask

    // One clock cycle: drive inputs at the negedge, compare, advance the model.
    task automatic runCycle(input bit rdy, input bit idRdy, input bit redir,
                            input logic [31:0] rpc, input int lat);
        bit          rspNow;
        bit          eReqV;
        bit          eIdV;
        logic [31:0] rdata;
        logic [31:0] eIdPc;
        logic [31:0] eInstr;
        infl_t       f;
        int          due;

        rspNow = (memQ.size() > 0) && (memQ[0].due <= cyc);
        rdata  = rspNow ? memData(memQ[0].addr) : $urandom;
        imem_req_ready = rdy;
        imem_rsp_valid = rspNow;
        imem_rsp_data  = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = idRdy;
        #1;

        eReqV  = ((mInfl.size() + mFifo.size()) < DEPTH) && !redir;
        eIdV   = (mFifo.size() > 0);
        eIdPc  = eIdV ? mFifo[0].pc    : 32'h0;
        eInstr = eIdV ? mFifo[0].instr : NOP;

        check1 ("req_valid", imem_req_valid, eReqV);
        check32("req_addr",  imem_req_addr,  mPc);
        check1 ("id_valid",  id_valid,       eIdV);
        check32("id_pc",     id_pc,          eIdPc);
        check32("id_instr",  id_instr,       eInstr);
        check32("id_opcode", {25'h0, id_opcode}, {25'h0, eInstr[6:0]});

        if (imem_req_valid && rdy) dutAccepts++;
        if (id_valid && idRdy)     consumed++;

        if (eIdV && idRdy) void'(mFifo.pop_front());
        if (rspNow) begin
            void'(memQ.pop_front());
            f = mInfl.pop_front();
            if (!f.stale && !redir) mFifo.push_back('{f.pc, rdata});
        end
        if (eReqV && rdy) begin
            due = cyc + lat;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{mPc, due});
            mInfl.push_back('{mPc, 1'b0});
            mPc = mPc + 32'd4;
        end
        if (redir) begin
            foreach (mInfl[i]) mInfl[i].stale = 1'b1;
            mFifo.delete();
            mPc = {rpc[31:2], 2'b00};
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit          seen;
        logic [31:0] rpc;

        //            rdy rspV data  rdr rpc           idR | reqV addr          idV idPc          instr
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         NOP};
        vecs[1]  = '{1'b1, 1'b1, D0,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         NOP};
        vecs[2]  = '{1'b1, 1'b1, D1,    1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, D0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, D1};
        vecs[4]  = '{1'b1, 1'b1, D2,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,         NOP};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, D2};
        vecs[6]  = '{1'b1, 1'b1, D3,    1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, D2};
        vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, D2};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         NOP};
        vecs[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         NOP};
        vecs[10] = '{1'b1, 1'b1, D4,    1'b1, 32'h200, 1'b1, 1'b0, 32'h0000_0104, 1'b0, 32'h0,         NOP};
        vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         NOP};
        vecs[12] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         NOP};
        vecs[13] = '{1'b1, 1'b1, D5,    1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0208, 1'b0, 32'h0,         NOP};
        vecs[14] = '{1'b1, 1'b1, D6,    1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200, D5};
        vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204, D6};

        // ---- directed table ----
        doReset();
        for (int i = 0; i < NVEC; i++) begin
            imem_req_ready = vecs[i].ready;
            imem_rsp_valid = vecs[i].rspValid;
            imem_rsp_data  = vecs[i].rspData;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redirPc;
            id_ready       = vecs[i].idReady;
            #1;
            check1 ($sformatf("tbl%0d_req_valid", i), imem_req_valid, vecs[i].eReqValid);
            check32($sformatf("tbl%0d_req_addr",  i), imem_req_addr,  vecs[i].eAddr);
            check1 ($sformatf("tbl%0d_id_valid",  i), id_valid,       vecs[i].eIdValid);
            check32($sformatf("tbl%0d_id_pc",     i), id_pc,          vecs[i].eIdPc);
            check32($sformatf("tbl%0d_id_instr",  i), id_instr,       vecs[i].eInstr);
            @(posedge clk);
            @(negedge clk);
        end

        // ---- 1-cycle memory, decode always ready ----
        doReset();
        repeat (20) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // ---- decode stalled: only DEPTH requests may be issued ----
        doReset();
        repeat (10) runCycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checkInt("stall_req_count", dutAccepts, DEPTH);
        checkInt("stall_consumed",  consumed,   0);
        repeat (10) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // ---- memory not ready: address must hold ----
        doReset();
        repeat (3) runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check32("hold_addr", imem_req_addr, RESET_PC);
        repeat (20) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 2);

        // ---- redirect with two requests in flight ----
        doReset();
        runCycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        runCycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        runCycle(1'b1, 1'b1, 1'b1, 32'h103, 1);
        check32("redirect_addr", imem_req_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (id_valid) begin
                seen = 1'b1;
                check32("redirect_first_id_pc", id_pc, 32'h100);
            end
        end
        check1("redirect_id_valid_seen", seen, 1'b1);

        // ---- redirect coinciding with a response and an id handshake ----
        doReset();
        runCycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        runCycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        runCycle(1'b1, 1'b1, 1'b1, 32'h40, 1);
        checkInt("redir_handshake_counted", consumed, 1);
        check1  ("redir_fifo_empty", id_valid, 1'b0);
        repeat (8) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // ---- PC wraps modulo 2^32 ----
        doReset();
        runCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1);
        runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check32("pc_wrap", imem_req_addr, 32'h0);
        repeat (6) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // ---- long random run ----
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 19) == 0, rpc, $urandom_range(1, 3));
        end

        // ---- reset mid-stream ----
        doReset();
        repeat (15) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 2);
        doReset();
        check32("restart_addr", imem_req_addr, RESET_PC);
        repeat (10) runCycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
